// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register placed between two stages of the five-stage core.
// It carries a data bundle, a control bundle and a valid bit. On each clock edge it does
// exactly one action, in priority order:
//   reset > flush > hold > bubble > normal load.
// A "killed" slot has valid cleared and the masked control bits forced to 0. Its data is
// either zeroed or taken from data_in, depending on CLEAR_DATA_ON_KILL.
// Saturating event counters feed the hazard-debug path.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   valid_in    upstream slot holds a real instruction
//   data_in     data bundle (DATA_W)
//   ctrl_in     control bundle (CTRL_W)
//   hold        stall: keep current contents
//   bubble      load a killed slot (NOP insertion)
//   flush       load a killed slot (redirect)
//   cnt_clr     synchronous clear of all counters
//   valid_out   registered valid
//   data_out    registered data
//   ctrl_out    registered control
//   hold_cnt    cycles in which hold took effect (saturating)
//   bubble_cnt  bubbles inserted (saturating)
//   flush_cnt   flushes taken (saturating)
//   hold_run    current consecutive-hold length (saturating)
module pipe_stage_reg #(
  parameter int unsigned        DATA_W             = 192,
  parameter int unsigned        CTRL_W             = 24,
  parameter logic [CTRL_W-1:0]  CTRL_KILL_MASK     = {CTRL_W{1'b1}},
  parameter bit                 CLEAR_DATA_ON_KILL = 1'b0,
  parameter int unsigned        CNT_W              = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CNT_W-1:0]  hold_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  hold_run
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  hold_run_q, hold_run_d;

  // Effective actions after priority resolution; a losing request is dropped, not deferred.
  logic flush_eff, hold_eff, bubble_eff, kill;

  logic [DATA_W-1:0] kill_data;
  logic [CTRL_W-1:0] kill_ctrl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CntMax) ? val : val + CNT_W'(1);
  endfunction

  assign flush_eff  = flush;
  assign hold_eff   = hold & ~flush;
  assign bubble_eff = bubble & ~hold & ~flush;
  assign kill       = flush_eff | bubble_eff;

  assign kill_data = CLEAR_DATA_ON_KILL ? '0 : data_in;
  assign kill_ctrl = ctrl_in & ~CTRL_KILL_MASK;

  // Pipeline contents
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (kill) begin
      valid_d = 1'b0;
      data_d  = kill_data;
      ctrl_d  = kill_ctrl;
    end else if (!hold_eff) begin
      valid_d = valid_in;
      data_d  = data_in;
      ctrl_d  = ctrl_in;
    end
  end

  // Event counters; cnt_clr discards this cycle's increment as well.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    hold_run_d   = '0;
    if (cnt_clr) begin
      hold_cnt_d   = '0;
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
      hold_run_d   = '0;
    end else begin
      if (hold_eff) begin
        hold_cnt_d = sat_inc(hold_cnt_q);
        hold_run_d = sat_inc(hold_run_q);
      end
      if (bubble_eff) begin
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      if (flush_eff) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      ctrl_q       <= '0;
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      hold_run_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      hold_run_q   <= hold_run_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign ctrl_out   = ctrl_q;
  assign hold_cnt   = hold_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign hold_run   = hold_run_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. It drives two instances from one stimulus stream:
//   dut a: partial kill mask 8'h0F, data passed through on kill, 3-bit counters
//   dut b: full kill mask, data cleared on kill, 16-bit counters
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [CW-1:0] ctrl_in;
  logic          hold, bubble, flush, cnt_clr;

  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_ctrl, b_ctrl;
  logic [2:0]    a_hcnt, a_bcnt, a_fcnt, a_hrun;
  logic [15:0]   b_hcnt, b_bcnt, b_fcnt, b_hrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W             (DW),
    .CTRL_W             (CW),
    .CTRL_KILL_MASK     (8'h0F),
    .CLEAR_DATA_ON_KILL (1'b0),
    .CNT_W              (3)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ctrl_in    (ctrl_in),
    .hold       (hold),
    .bubble     (bubble),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .valid_out  (a_valid),
    .data_out   (a_data),
    .ctrl_out   (a_ctrl),
    .hold_cnt   (a_hcnt),
    .bubble_cnt (a_bcnt),
    .flush_cnt  (a_fcnt),
    .hold_run   (a_hrun)
  );

  pipe_stage_reg #(
    .DATA_W             (DW),
    .CTRL_W             (CW),
    .CTRL_KILL_MASK     (8'hFF),
    .CLEAR_DATA_ON_KILL (1'b1),
    .CNT_W              (16)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ctrl_in    (ctrl_in),
    .hold       (hold),
    .bubble     (bubble),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .valid_out  (b_valid),
    .data_out   (b_data),
    .ctrl_out   (b_ctrl),
    .hold_cnt   (b_hcnt),
    .bubble_cnt (b_bcnt),
    .flush_cnt  (b_fcnt),
    .hold_run   (b_hrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic h, input logic b, input logic f);
    valid_in = v;
    data_in  = d;
    ctrl_in  = c;
    hold     = h;
    bubble   = b;
    flush    = f;
  endtask

  initial begin
    rst     = 1'b0;
    cnt_clr = 1'b0;
    drive(1'b1, '1, '1, 1'b1, 1'b0, 1'b0);

    // Reset overrides everything, even an active hold.
    repeat (3) tick();
    check("rst a_valid", a_valid, 0);
    check("rst a_data", a_data, 0);
    check("rst a_ctrl", a_ctrl, 0);
    check("rst a_hcnt", a_hcnt, 0);
    check("rst a_hrun", a_hrun, 0);
    check("rst b_valid", b_valid, 0);
    check("rst b_data", b_data, 0);
    check("rst b_fcnt", b_fcnt, 0);
    check("rst b_bcnt", b_bcnt, 0);

    // Normal load of an invalid slot: ctrl passes unmasked.
    rst = 1'b1;
    drive(1'b0, 32'h31, 8'h0F, 1'b0, 1'b0, 1'b0);
    tick();
    check("ld0 a_valid", a_valid, 0);
    check("ld0 a_data", a_data, 32'h31);
    check("ld0 a_ctrl", a_ctrl, 8'h0F);

    // Load then hold for 4 cycles while data_in changes.
    drive(1'b1, 32'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick();
    check("ld a_valid", a_valid, 1);
    check("ld a_data", a_data, 32'hA5);
    check("ld a_ctrl", a_ctrl, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + i, 8'hC3, 1'b1, 1'b0, 1'b0);
      tick();
      check("hold a_data", a_data, 32'hA5);
      check("hold b_ctrl", b_ctrl, 8'h3C);
      check("hold a_hrun", a_hrun, i + 1);
      check("hold b_hcnt", b_hcnt, i + 1);
    end
    drive(1'b1, 32'h55, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    check("rel a_hrun", a_hrun, 0);
    check("rel a_hcnt", a_hcnt, 4);
    check("rel a_data", a_data, 32'h55);

    // Bubble with partial and full masks.
    drive(1'b1, 32'h77, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    check("bub a_valid", a_valid, 0);
    check("bub a_ctrl", a_ctrl, 8'hF0);
    check("bub a_data", a_data, 32'h77);
    check("bub a_bcnt", a_bcnt, 1);
    check("bub b_ctrl", b_ctrl, 8'h00);
    check("bub b_data", b_data, 0);
    check("bub b_bcnt", b_bcnt, 1);

    // flush + hold + bubble: flush wins, others not counted.
    drive(1'b1, 32'h88, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick();
    check("fhb a_valid", a_valid, 0);
    check("fhb a_ctrl", a_ctrl, 8'hF0);
    check("fhb a_data", a_data, 32'h88);
    check("fhb a_fcnt", a_fcnt, 1);
    check("fhb a_hcnt", a_hcnt, 4);
    check("fhb a_bcnt", a_bcnt, 1);
    check("fhb a_hrun", a_hrun, 0);

    // The killed slot is overwritten by the next normal load.
    drive(1'b1, 32'h99, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick();
    check("ovw a_valid", a_valid, 1);
    check("ovw a_ctrl", a_ctrl, 8'h5A);

    // hold + bubble: hold wins, bubble dropped.
    drive(1'b1, 32'hAA, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick();
    check("hb a_valid", a_valid, 1);
    check("hb a_data", a_data, 32'h99);
    check("hb a_ctrl", a_ctrl, 8'h5A);
    check("hb a_hcnt", a_hcnt, 5);
    check("hb a_bcnt", a_bcnt, 1);
    check("hb a_hrun", a_hrun, 1);

    // Saturation: 10 more holds on an invalid slot input.
    drive(1'b0, 32'hBB, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    check("sat a_hcnt", a_hcnt, 7);
    check("sat a_hrun", a_hrun, 7);
    check("sat b_hcnt", b_hcnt, 15);
    check("sat b_hrun", b_hrun, 11);
    check("sat a_data", a_data, 32'h99);

    // Clear during hold discards that cycle's increment.
    cnt_clr = 1'b1;
    tick();
    check("clr a_hcnt", a_hcnt, 0);
    check("clr a_hrun", a_hrun, 0);
    check("clr a_fcnt", a_fcnt, 0);
    check("clr b_bcnt", b_bcnt, 0);
    check("clr a_valid", a_valid, 1);
    cnt_clr = 1'b0;
    tick();
    check("clr1 a_hcnt", a_hcnt, 1);
    check("clr1 a_hrun", a_hrun, 1);

    // Flush with data clearing on b.
    drive(1'b1, 32'h1234, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    check("fl b_data", b_data, 0);
    check("fl b_valid", b_valid, 0);
    check("fl b_ctrl", b_ctrl, 0);
    check("fl b_fcnt", b_fcnt, 1);
    check("fl a_data", a_data, 32'h1234);
    check("fl a_hrun", a_hrun, 0);

    // Reset during a flush after a valid load.
    drive(1'b1, 32'h42, 8'h42, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre a_data", a_data, 32'h42);
    drive(1'b1, 32'h1234, 8'hFF, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    check("rfl a_data", a_data, 0);
    check("rfl a_ctrl", a_ctrl, 0);
    check("rfl a_valid", a_valid, 0);
    check("rfl a_hcnt", a_hcnt, 0);
    check("rfl b_fcnt", b_fcnt, 0);
    check("rfl b_data", b_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register used between any two stages of the five-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data bundle and a control bundle plus a valid bit. Each cycle it performs one of four actions, in priority order: flush, hold, bubble insert or normal load. Masked control bits are cleared whenever the slot is killed. Saturating event counters feed the hazard-debug path.

## Interface
Parameters:
- DATA_W, 192, width of the data bundle (PC, inst, imm, register indices/data, packed by the instantiator)
- CTRL_W, 24, width of the control bundle
- CTRL_KILL_MASK, {CTRL_W{1'b1}}, bit i = 1 means ctrl bit i is forced to 0 on a killed slot (RegWrite, MemWrite, MemRead, branch/jump flags)
- CLEAR_DATA_ON_KILL, 0, 1 means data_out is zeroed on a killed slot; 0 means data is loaded from data_in
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- valid_in  in  1  upstream slot holds a real instruction
- data_in  in  DATA_W  data bundle
- ctrl_in  in  CTRL_W  control bundle
- hold  in  1  stall: keep current contents
- bubble  in  1  load a killed slot (hazard-unit NOP insertion)
- flush  in  1  load a killed slot (branch/jump redirect)
- cnt_clr  in  1  synchronous clear of all counters
- valid_out  out  1  registered valid
- data_out  out  DATA_W  registered data
- ctrl_out  out  CTRL_W  registered control
- hold_cnt  out  CNT_W  number of cycles in which hold took effect, saturating
- bubble_cnt  out  CNT_W  number of bubbles inserted, saturating
- flush_cnt  out  CNT_W  number of flushes, saturating
- hold_run  out  CNT_W  current consecutive-hold length, saturating

## Operation
- Killed slot: valid_out=0 and ctrl_out = ctrl_in & ~CTRL_KILL_MASK. data_out = 0 if CLEAR_DATA_ON_KILL=1, otherwise data_out = data_in.
- Action priority on each rising edge of clk:
  1. rst=0: valid_out, data_out, ctrl_out, all counters and hold_run go to 0.
  2. flush=1: load a killed slot. flush_cnt increments. hold_run goes to 0.
  3. hold=1: valid_out, data_out and ctrl_out keep their values. hold_cnt and hold_run increment.
  4. bubble=1: load a killed slot. bubble_cnt increments. hold_run goes to 0.
  5. Otherwise: load valid_in, data_in and ctrl_in unchanged. hold_run goes to 0.
- The signal that loses priority is ignored for that cycle. It is not counted, and its event is not deferred.
- A killed slot is a full load. The next non-hold cycle overwrites it normally.
- All counters saturate at 2^CNT_W-1 and do not wrap.
- cnt_clr=1: all four counters go to 0 in that cycle. The increment for that cycle is discarded. The pipeline action is unaffected.
- Counters do not depend on valid_in. A hold on an invalid slot is still counted.

## Timing
- Latency is 1 cycle from the inputs to valid_out, data_out and ctrl_out.
- hold, bubble and flush are sampled on the same edge as the data.
- Every output is a direct register output with no combinational path from the inputs.
- Reset applies on the first rising edge with rst=0 and takes priority over every other input.
- If rst is asserted mid-hold, the slot empties and hold_run clears on that same edge.
- Counter outputs update on the same edge as the action they count.

## Test plan
- Reset: drive valid_in=1, data_in=all-ones, ctrl_in=all-ones and hold=1 for 3 cycles with rst=0 -> valid_out=0, data_out=0, ctrl_out=0, all counters 0.
- Load then hold: load data_in=0x...A5 and valid_in=1, then assert hold for 4 cycles while data_in changes every cycle -> data_out stays 0x...A5, hold_cnt=4, hold_run counts 1,2,3,4, then returns to 0 on release.
- Bubble with a partial mask: CTRL_W=8, CTRL_KILL_MASK=8'h0F, ctrl_in=8'hFF, bubble=1 -> valid_out=0, ctrl_out=8'hF0, data_out=data_in, bubble_cnt=1.
- Simultaneous events: assert flush=1, hold=1 and bubble=1 together -> killed slot, flush_cnt=1, hold_cnt and bubble_cnt unchanged. Then assert hold=1 and bubble=1 -> contents held, hold_cnt=1, bubble_cnt unchanged.
- Counter saturation and clear: CNT_W=3 with hold=1 for 10 cycles -> hold_cnt stops at 7. Then cnt_clr=1 while hold=1 -> hold_cnt=0 on that edge and 1 on the next edge.
- CLEAR_DATA_ON_KILL=1 with flush=1 and data_in=0x1234 -> data_out=0. Reset pulse during that flush -> reset wins and all outputs are 0.
